// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, machine word, and the memory arbiter's
// state encoding and default limits.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IACC  = 3'd1,
    DACC  = 3'd2,
    RESP  = 3'd3,
    FAULT = 3'd4
  } arb_state_t;

  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_TIMEOUT    = 64;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the unified RAM and the arbiter.
// Handshake: a requester holds xREN/xWEN and its operands steady until it sees
// its one-cycle hit strobe; the RAM answers an enable with ramstate (ACCESS
// completes the transfer, FREE/BUSY stall, ERROR aborts).
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      ihit;
  logic      dhit;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_timeout_counter.sv
// Saturating up-counter with synchronous clear; o_expired flags that the count
// has reached MAX. Clear takes priority over enable.
module arb_timeout_counter #(
  parameter int MAX = 63,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [W-1:0] LP_MAX = W'(MAX);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LP_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LP_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Unified-RAM arbiter: data-over-fetch priority with a fetch starvation guard,
// registered transfer operands and a sticky RAM timeout/error fault.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic                CLK,
  input  logic                RST,
  mem_arbiter_if.slave        bus,
  output logic                fault,
  output arb_state_t          o_dbg_state
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_op_data;
  logic       r_op_write;
  word_t      r_addr;
  word_t      r_store;
  word_t      r_iload;
  word_t      r_dload;

  logic w_dreq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_in_acc;
  logic w_access;
  logic w_starved;
  logic w_tmo_exp;

  assign w_dreq   = bus.dREN | bus.dWEN;
  assign w_in_acc = (r_state == IACC) || (r_state == DACC);
  assign w_access = w_in_acc && (bus.ramstate == ACCESS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    case (r_state)
      IDLE: begin
        // Data wins unless fetch has already lost STARVE_MAX grants in a row.
        if (w_dreq && (!w_starved || !bus.iREN)) begin
          w_grant_d = 1'b1;
          w_next    = DACC;
        end else if (bus.iREN) begin
          w_grant_i = 1'b1;
          w_next    = IACC;
        end
      end
      IACC, DACC: begin
        if (bus.ramstate == ACCESS) begin
          w_next = RESP;
        end else if ((bus.ramstate == ERROR) || w_tmo_exp) begin
          w_next = FAULT;
        end
      end
      RESP:    w_next = IDLE;
      FAULT:   w_next = FAULT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op_data  <= 1'b0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_store    <= '0;
      r_iload    <= '0;
      r_dload    <= '0;
    end else begin
      if (w_grant_d) begin
        r_op_data  <= 1'b1;
        r_op_write <= bus.dWEN;
        r_addr     <= bus.daddr;
        r_store    <= bus.dstore;
      end else if (w_grant_i) begin
        r_op_data  <= 1'b0;
        r_op_write <= 1'b0;
        r_addr     <= bus.iaddr;
      end
      if (w_access && (r_state == IACC)) r_iload <= bus.ramload;
      if (w_access && (r_state == DACC) && !r_op_write) r_dload <= bus.ramload;
    end
  end

  arb_timeout_counter #(.MAX(STARVE_MAX)) u_starve (
    .CLK       (CLK),
    .RST       (RST),
    .i_clr     (w_grant_i),
    .i_en      (w_grant_d && bus.iREN),
    .o_expired (w_starved)
  );

  // Expires on the TIMEOUT-th access cycle without ACCESS.
  arb_timeout_counter #(.MAX(TIMEOUT - 1)) u_timeout (
    .CLK       (CLK),
    .RST       (RST),
    .i_clr     (!w_in_acc || w_access),
    .i_en      (w_in_acc),
    .o_expired (w_tmo_exp)
  );

  assign bus.ramREN   = (r_state == IACC) || ((r_state == DACC) && !r_op_write);
  assign bus.ramWEN   = (r_state == DACC) && r_op_write;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
  assign bus.ihit     = (r_state == RESP) && !r_op_data;
  assign bus.dhit     = (r_state == RESP) && r_op_data;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign fault        = (r_state == FAULT);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, wait states,
// fault paths and asynchronous reset, with hand-computed expected values.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       RST;
  logic       fault;
  arb_state_t dbg_state;
  int         n_checks;
  int         n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .fault       (fault),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) check("hit_exclusive", 32'(bus.ihit & bus.dhit), 32'd0);
  end

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    RST          = 1'b1;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    idle_inputs();
    #2;
    check("async_reset_state", 32'(dbg_state), 32'd0);
    do_reset();

    // Reset values
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_ihit", 32'(bus.ihit), 32'd0);
    check("rst_dhit", 32'(bus.dhit), 32'd0);
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_iload", bus.iload, 32'h0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);

    // Fetch only, zero-wait RAM
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    tick();
    check("f_state_iacc", 32'(dbg_state), 32'd1);
    check("f_ramREN", 32'(bus.ramREN), 32'd1);
    check("f_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("f_ramaddr", bus.ramaddr, 32'h40);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h8C010004;
    tick();
    check("f_ihit", 32'(bus.ihit), 32'd1);
    check("f_iload", bus.iload, 32'h8C010004);
    check("f_dhit", 32'(bus.dhit), 32'd0);
    check("f_resp_ramREN", 32'(bus.ramREN), 32'd0);
    idle_inputs();
    tick();
    check("f_back_idle", 32'(dbg_state), 32'd0);
    check("f_ihit_drop", 32'(bus.ihit), 32'd0);

    // Simultaneous fetch and data write: data first
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h44;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h100;
    bus.dstore = 32'hDEADBEEF;
    tick();
    check("s_state_dacc", 32'(dbg_state), 32'd2);
    check("s_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("s_ramREN", 32'(bus.ramREN), 32'd0);
    check("s_ramaddr", bus.ramaddr, 32'h100);
    check("s_ramstore", bus.ramstore, 32'hDEADBEEF);
    bus.ramstate = ACCESS;
    tick();
    check("s_dhit", 32'(bus.dhit), 32'd1);
    check("s_ihit_low", 32'(bus.ihit), 32'd0);
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    check("s_idle", 32'(dbg_state), 32'd0);
    tick();
    check("s_fetch_granted", 32'(dbg_state), 32'd1);
    check("s_fetch_addr", bus.ramaddr, 32'h44);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h00A0_0001;
    tick();
    check("s_ihit", 32'(bus.ihit), 32'd1);
    check("s_iload", bus.iload, 32'h00A0_0001);
    idle_inputs();
    tick();

    // Starvation guard: four data grants, then fetch, then data again
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h80;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("st_grant%0d", k), 32'(dbg_state), (k < 4) ? 32'd2 : 32'd1);
      bus.ramstate = ACCESS;
      bus.ramload  = 32'h1000 + 32'(k);
      tick();
      check($sformatf("st_dhit%0d", k), 32'(bus.dhit), (k < 4) ? 32'd1 : 32'd0);
      check($sformatf("st_ihit%0d", k), 32'(bus.ihit), (k < 4) ? 32'd0 : 32'd1);
      if (k == 3) check("st_dload3", bus.dload, 32'h1003);
      if (k == 4) check("st_iload", bus.iload, 32'h1004);
      bus.ramstate = FREE;
      tick();
    end
    tick();
    check("st_cleared_data_first", 32'(dbg_state), 32'd2);
    bus.ramstate = ACCESS;
    tick();
    idle_inputs();
    tick();

    // Wait states with operands changing mid-access
    bus.dREN  = 1'b1;
    bus.daddr = 32'h300;
    tick();
    check("w_ramREN_c1", 32'(bus.ramREN), 32'd1);
    check("w_ramaddr_c1", bus.ramaddr, 32'h300);
    bus.ramstate = BUSY;
    bus.daddr    = 32'hFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("w_ramREN_c%0d", i + 2), 32'(bus.ramREN), 32'd1);
      check($sformatf("w_ramaddr_c%0d", i + 2), bus.ramaddr, 32'h300);
      check($sformatf("w_no_hit_c%0d", i + 2), 32'(bus.dhit), 32'd0);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h1234;
    tick();
    check("w_dhit", 32'(bus.dhit), 32'd1);
    check("w_dload", bus.dload, 32'h1234);
    idle_inputs();
    tick();

    // ERROR during fetch
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h50;
    tick();
    bus.ramstate = ERROR;
    tick();
    check("e_fault", 32'(fault), 32'd1);
    check("e_ramREN", 32'(bus.ramREN), 32'd0);
    check("e_ihit", 32'(bus.ihit), 32'd0);
    bus.ramstate = FREE;
    tick();
    check("e_sticky", 32'(fault), 32'd1);
    check("e_no_regrant", 32'(dbg_state), 32'd4);
    idle_inputs();
    do_reset();
    check("e_rst_clears", 32'(fault), 32'd0);

    // Timeout: BUSY for 64 access cycles
    bus.dREN  = 1'b1;
    bus.daddr = 32'h400;
    tick();
    bus.ramstate = BUSY;
    for (int i = 0; i < 63; i++) tick();
    check("t_no_fault_63", 32'(fault), 32'd0);
    check("t_still_dacc", 32'(dbg_state), 32'd2);
    tick();
    check("t_fault_64", 32'(fault), 32'd1);
    check("t_ramREN_off", 32'(bus.ramREN), 32'd0);
    idle_inputs();
    do_reset();
    check("t_rst_clears", 32'(fault), 32'd0);
    check("t_rst_state", 32'(dbg_state), 32'd0);

    // Asynchronous reset in the middle of a data write
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h500;
    bus.dstore = 32'h55;
    tick();
    check("a_ramWEN_before", 32'(bus.ramWEN), 32'd1);
    bus.ramstate = BUSY;
    #3;
    RST = 1'b1;
    #1;
    check("a_ramWEN_now", 32'(bus.ramWEN), 32'd0);
    check("a_state_idle", 32'(dbg_state), 32'd0);
    idle_inputs();
    tick();
    RST = 1'b0;
    tick();
    check("a_no_dhit", 32'(bus.dhit), 32'd0);
    check("a_idle_after", 32'(dbg_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
